kyber_mod_adder: RTL and testbench
==================================

Name: kyber_mod_adder

Overview:
- Registered modular adder/subtractor over Z_Q, Q = 3329 (Kyber prime), used by the NTT butterfly datapath.
- Takes two reduced 12-bit coefficients and returns (a + b) mod Q or (a − b) mod Q.
- Result is registered, with a single-cycle latency and a valid strobe.
- Fully pipelined: accepts one operation per clock.

Parameters:
- Q, 3329, modulus; must satisfy 2 ≤ Q < 2^W.
- W, 12, coefficient width in bits.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands valid this cycle.
- sub  in  1  0 = add, 1 = subtract (a − b).
- a  in  W  first operand; legal range 0..Q−1.
- b  in  W  second operand; legal range 0..Q−1.
- out_valid  out  1  result valid; equals in_valid delayed one cycle.
- result  out  W  reduced result, 0..Q−1 for legal inputs.
- range_err  out  1  registered alongside result; 1 if a ≥ Q or b ≥ Q in the accepted operation.

Behaviour:
- Reset: asynchronous, active-high. While rst = 1: out_valid = 0, result = 0, range_err = 0, immediately and independent of clk.
- Reset mid-stream: an in-flight operation is discarded. The first valid input after rst deasserts produces out_valid one cycle later.
- Latency: exactly 1 clock. Operands sampled at rising edge N appear on result/out_valid after edge N.
- No backpressure; there is no stall input. One result per valid input, in order.
- Hold when idle: when in_valid = 0, result and range_err hold their previous values and out_valid = 0 on the next cycle.
- Add path:
  - s = a + b computed at W+1 bits (no overflow; max 2Q−2).
  - result = s − Q if s ≥ Q, else s.
  - Single conditional subtraction, no division.
- Subtract path:
  - d = a − b computed at W+1 bits signed/borrow.
  - result = d + Q if borrow (a < b), else d.
- Boundaries:
  - s = Q exactly → 0.
  - s = Q−1 → Q−1 (no wrap).
  - (Q−1) + (Q−1) → Q−2.
  - a = b on sub → 0.
  - 0 − 1 → Q−1.
- Out-of-range inputs:
  - range_err = 1 for that result.
  - result is still produced by the same single-correction formula, truncated to W bits, and is not guaranteed reduced.
  - No other side effects.
- Combinational path from inputs to registers is a W+1-bit adder, a comparator/borrow, and a mux; no multi-cycle paths.

Decomposition:
- Shared package ntt_pkg holds:
  - localparam Q = 3329 and W = 12;
  - typedef coeff_t as logic [W-1:0].
- One sub-module is natural: mod_addsub_comb, the purely combinational reduce-after-add/sub (a, b, sub → result, range_err).
- kyber_mod_adder wraps mod_addsub_comb with the output register and valid pipeline.

Test Plan:
- Add, no wrap and zero case:
  - add, a=3328, b=0 → result 3328 one cycle later, out_valid=1, range_err=0.
  - add, a=0, b=0 → result 0.
- Add, wrap cases:
  - exact wrap: a=3000, b=329 → result 0.
  - just above Q: a=3000, b=330 → result 1.
  - max + max: a=3328, b=3328 → result 3327.
- Subtract cases:
  - sub, a=0, b=1 → result 3328.
  - sub, a=5, b=5 → 0.
  - sub, a=3328, b=0 → 3328.
- Back-to-back and error flag:
  - stream 4 valid ops on consecutive cycles → 4 results on consecutive cycles, in order.
  - in_valid=0 cycle → out_valid=0 and result holds.
  - add, a=3329, b=0 → range_err=1.
- Reset behaviour:
  - assert rst asynchronously (mid-cycle) with an op in flight → out_valid, result, range_err go to 0 immediately.
  - after release, next op (a=1, b=2) → result 3 one cycle later.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared constants and types for the Kyber NTT datapath (modulus, coefficient width).
package ntt_pkg;

  // Kyber prime and the coefficient width that holds any reduced value
  localparam int Q = 3329;
  localparam int W = 12;

  typedef logic [W-1:0] coeff_t;

  // True when a coefficient is already reduced, i.e. a legal operand
  function automatic logic coeff_in_range(input coeff_t c);
    return (c < coeff_t'(Q));
  endfunction

endpackage

// File: rtl/mod_addsub_comb.sv
// Combinational modular add/subtract with a single conditional correction.
// Out-of-range operands still go through the same correction and are flagged.
module mod_addsub_comb
  import ntt_pkg::*;
#(
  parameter int MQ = Q,
  parameter int MW = W
) (
  input  logic          sub,
  input  logic [MW-1:0] a,
  input  logic [MW-1:0] b,
  output logic [MW-1:0] result,
  output logic          range_err
);

  // Modulus at both the extended (carry/borrow) width and the result width
  localparam logic [MW:0]   Q_EXT = (MW+1)'(MQ);
  localparam logic [MW-1:0] Q_NAR = MW'(MQ);

  logic [MW:0]   sum_ext;
  logic [MW:0]   diff_ext;
  logic [MW:0]   sum_red;
  logic          sum_ge_q;
  logic          borrow;
  logic [MW-1:0] add_res;
  logic [MW-1:0] sub_res;

  // One extra bit keeps the carry of a+b and the borrow of a-b
  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};

  // Operands fit in MW bits, so the top bit of the difference is exactly the borrow
  assign borrow   = diff_ext[MW];
  assign sum_ge_q = (sum_ext >= Q_EXT);
  assign sum_red  = sum_ext - Q_EXT;

  // Per-path correction and final mux; truncation to MW bits is intentional
  always_comb begin
    add_res = sum_ge_q ? sum_red[MW-1:0] : sum_ext[MW-1:0];
    sub_res = borrow ? (diff_ext[MW-1:0] + Q_NAR) : diff_ext[MW-1:0];
    result  = sub ? sub_res : add_res;
  end

  assign range_err = (a >= Q_NAR) || (b >= Q_NAR);

endmodule

// File: rtl/kyber_mod_adder.sv
// Registered modular adder/subtractor over Z_Q for the NTT butterfly.
// One-cycle latency, one operation per clock, no backpressure.
module kyber_mod_adder
  import ntt_pkg::*;
#(
  parameter int Q_P = Q,
  parameter int W_P = W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic           sub,
  input  logic [W_P-1:0] a,
  input  logic [W_P-1:0] b,
  output logic           out_valid,
  output logic [W_P-1:0] result,
  output logic           range_err
);

  logic [W_P-1:0] comb_result;
  logic           comb_range_err;

  mod_addsub_comb #(
    .MQ (Q_P),
    .MW (W_P)
  ) u_comb (
    .sub       (sub),
    .a         (a),
    .b         (b),
    .result    (comb_result),
    .range_err (comb_range_err)
  );

  // Output register: valid follows in_valid; data only updates on accepted ops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      range_err <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result    <= comb_result;
        range_err <= comb_range_err;
      end
    end
  end

endmodule

// File: tb/tb_kyber_mod_adder.sv
// Self-checking bench for kyber_mod_adder: directed boundary cases, streaming,
// idle hold, asynchronous reset and randomized operations against a model.
module tb_kyber_mod_adder;

  localparam int QM = 3329;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        sub;
  logic [11:0] a;
  logic [11:0] b;
  logic        out_valid;
  logic [11:0] result;
  logic        range_err;

  int vectors    = 0;
  int miscompares = 0;

  int last_res;
  int last_err;

  kyber_mod_adder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .result    (result),
    .range_err (range_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: true modular arithmetic for legal operands, the single-correction
  // rule truncated to 12 bits otherwise.
  function automatic int model_res(input int s, input int x, input int y);
    int r;
    if (x < QM && y < QM) begin
      if (s != 0) r = ((x - y) % QM + QM) % QM;
      else        r = (x + y) % QM;
    end else begin
      if (s != 0) r = (x < y) ? (x - y + QM) : (x - y);
      else        r = (x + y >= QM) ? (x + y - QM) : (x + y);
      r = r & 12'hFFF;
    end
    return r;
  endfunction

  function automatic int model_err(input int x, input int y);
    return (x >= QM || y >= QM) ? 1 : 0;
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one op at the falling edge, check outputs just after the next rising edge
  task automatic do_op(input string tag, input int s, input int x, input int y);
    @(negedge clk);
    in_valid = 1'b1;
    sub = s[0];
    a = x[11:0];
    b = y[11:0];
    @(posedge clk);
    #1;
    last_res = model_res(s, x, y);
    last_err = model_err(x, y);
    $display("op %s: sub=%0d a=%0d b=%0d -> result=%0d range_err=%0d", tag, s, x, y, result, range_err);
    chk({tag, ".valid"}, int'(out_valid), 1);
    chk({tag, ".result"}, int'(result), last_res);
    chk({tag, ".err"}, int'(range_err), last_err);
  endtask

  task automatic idle_cycle(input string tag);
    @(negedge clk);
    in_valid = 1'b0;
    a = 12'($urandom_range(0, 4095));
    b = 12'($urandom_range(0, 4095));
    sub = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    $display("idle %s: out_valid=%0d result=%0d", tag, out_valid, result);
    chk({tag, ".valid"}, int'(out_valid), 0);
    chk({tag, ".hold"}, int'(result), last_res);
    chk({tag, ".holderr"}, int'(range_err), last_err);
  endtask

  initial begin
    int s, x, y;
    rst = 1'b1;
    in_valid = 1'b0;
    sub = 1'b0;
    a = '0;
    b = '0;
    last_res = 0;
    last_err = 0;

    // Reset state, observed before any clock edge
    #1;
    chk("rst.valid", int'(out_valid), 0);
    chk("rst.result", int'(result), 0);
    chk("rst.err", int'(range_err), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Add, no wrap and zero
    do_op("add_max_0", 0, 3328, 0);
    do_op("add_0_0", 0, 0, 0);
    // Add, wrap
    do_op("add_exact_q", 0, 3000, 329);
    do_op("add_q_plus1", 0, 3000, 330);
    do_op("add_max_max", 0, 3328, 3328);
    do_op("add_q_minus1", 0, 3000, 328);
    // Subtract
    do_op("sub_0_1", 1, 0, 1);
    do_op("sub_eq", 1, 5, 5);
    do_op("sub_max_0", 1, 3328, 0);
    do_op("sub_0_max", 1, 0, 3328);
    // Back-to-back stream of four, then an idle cycle
    do_op("stream0", 0, 1000, 2500);
    do_op("stream1", 1, 17, 3000);
    do_op("stream2", 0, 3328, 1);
    do_op("stream3", 1, 3328, 3327);
    idle_cycle("idle0");
    idle_cycle("idle1");
    // Out-of-range operands
    do_op("err_a_q", 0, 3329, 0);
    do_op("err_b_max", 1, 10, 4095);
    do_op("err_both", 0, 4095, 4095);
    idle_cycle("idle_err");

    // Asynchronous reset mid-cycle with an op in flight
    @(negedge clk);
    in_valid = 1'b1;
    sub = 1'b0;
    a = 12'd1234;
    b = 12'd2000;
    #2;
    rst = 1'b1;
    #1;
    $display("async reset asserted: out_valid=%0d result=%0d range_err=%0d", out_valid, result, range_err);
    chk("arst.valid", int'(out_valid), 0);
    chk("arst.result", int'(result), 0);
    chk("arst.err", int'(range_err), 0);
    @(posedge clk);
    #1;
    chk("arst.held", int'(out_valid), 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    last_res = 0;
    last_err = 0;
    idle_cycle("post_rst");
    do_op("post_rst_1_2", 0, 1, 2);

    // Randomized legal ops with occasional gaps and illegal operands
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        idle_cycle("rnd_idle");
      end else begin
        s = int'($urandom_range(0, 1));
        if ($urandom_range(0, 15) == 0) begin
          x = int'($urandom_range(0, 4095));
          y = int'($urandom_range(QM, 4095));
        end else begin
          x = int'($urandom_range(0, QM - 1));
          y = int'($urandom_range(0, QM - 1));
        end
        do_op("rnd", s, x, y);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
